pll_reset_sequencer: RTL and testbench

- Controller for the core PLL instance; runs on the free-running board reference clock.
- Drives the PLL reset and monitors the PLL `locked` output through a synchroniser and a consecutive-cycle filter.
- Releases the core reset only after a stable lock, and re-sequences the PLL on loss of lock or on software request.
- Bounded retries; raises a sticky fault when the PLL never locks.

---
 rtl/pll_reset_sequencer_if.sv | 37 +++
 rtl/pll_reset_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_pll_reset_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL / core logic it controls.
// The sequencer drives the reset and status signals; the PLL side supplies lock and relock requests.
interface pll_reset_sequencer_if;
  logic       pll_locked_in;
  logic       relock_req;
  logic       pll_rst;
  logic       core_rst;
  logic       ready;
  logic       lock_lost;
  logic       fault;
  logic [3:0] retry_cnt;
  logic [7:0] lost_cnt;

  modport master (
    input  pll_locked_in,
    input  relock_req,
    output pll_rst,
    output core_rst,
    output ready,
    output lock_lost,
    output fault,
    output retry_cnt,
    output lost_cnt
  );

  modport slave (
    output pll_locked_in,
    output relock_req,
    input  pll_rst,
    input  core_rst,
    input  ready,
    input  lock_lost,
    input  fault,
    input  retry_cnt,
    input  lost_cnt
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// Sequences the core PLL reset: holds pll_rst, waits for a filtered lock, delays core reset
// release, and re-sequences on loss of lock or relock request with bounded retries and a sticky fault.
module pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int FILTER_CYCLES       = 256,
  parameter int CORE_DELAY_CYCLES   = 64,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master bus
);
  localparam int MAX_AB  = (RST_HOLD_CYCLES > LOCK_TIMEOUT_CYCLES) ? RST_HOLD_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_ABC = (MAX_AB > FILTER_CYCLES) ? MAX_AB : FILTER_CYCLES;
  localparam int MAX_CYC = (MAX_ABC > CORE_DELAY_CYCLES) ? MAX_ABC : CORE_DELAY_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC) + 1;

  localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE      = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] FILT_LAST    = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST    = CNT_W'(CORE_DELAY_CYCLES - 1);
  localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_FILTER    = 3'd2,
    ST_CORE_HOLD = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] timer_r, timer_s;
  logic [CNT_W-1:0] filt_r, filt_s;
  logic             meta_r, lock_sync_r;
  logic             pll_rst_r, pll_rst_s;
  logic             core_rst_r, core_rst_s;
  logic             ready_r, ready_s;
  logic             lock_lost_r, lock_lost_s;
  logic             fault_r, fault_s;
  logic [3:0]       retry_r, retry_s;
  logic [7:0]       lost_r, lost_s;
  logic             loss_s;

  // Next-state and next-output decode; the timeout in WAIT_LOCK/FILTER outranks lock progress.
  always_comb begin
    state_s     = state_r;
    timer_s     = timer_r;
    filt_s      = filt_r;
    pll_rst_s   = pll_rst_r;
    core_rst_s  = core_rst_r;
    ready_s     = ready_r;
    lock_lost_s = 1'b0;
    fault_s     = fault_r;
    retry_s     = retry_r;
    lost_s      = lost_r;
    loss_s      = 1'b0;
    case (state_r)
      ST_PLL_RST: begin
        if (timer_r == HOLD_LAST) begin
          state_s   = ST_WAIT_LOCK;
          timer_s   = CNT_ZERO;
          pll_rst_s = 1'b0;
        end else begin
          timer_s = timer_r + CNT_ONE;
        end
      end
      ST_WAIT_LOCK, ST_FILTER: begin
        if (timer_r == TIMEOUT_LAST) begin
          timer_s   = CNT_ZERO;
          filt_s    = CNT_ZERO;
          pll_rst_s = 1'b1;
          if (retry_r == RETRY_LIMIT) begin
            state_s = ST_FAULT;
            fault_s = 1'b1;
          end else begin
            state_s = ST_PLL_RST;
            retry_s = (retry_r == 4'hF) ? retry_r : retry_r + 4'd1;
          end
        end else if (state_r == ST_WAIT_LOCK) begin
          timer_s = timer_r + CNT_ONE;
          if (lock_sync_r) begin
            state_s = ST_FILTER;
            filt_s  = CNT_ZERO;
          end else begin
            state_s = ST_WAIT_LOCK;
          end
        end else if (!lock_sync_r) begin
          timer_s = timer_r + CNT_ONE;
          state_s = ST_WAIT_LOCK;
          filt_s  = CNT_ZERO;
        end else if (filt_r == FILT_LAST) begin
          state_s = ST_CORE_HOLD;
          timer_s = CNT_ZERO;
        end else begin
          timer_s = timer_r + CNT_ONE;
          filt_s  = filt_r + CNT_ONE;
        end
      end
      ST_CORE_HOLD: begin
        if (!lock_sync_r) begin
          loss_s = 1'b1;
        end else if (timer_r == CORE_LAST) begin
          state_s    = ST_RUN;
          core_rst_s = 1'b0;
          ready_s    = 1'b1;
          retry_s    = 4'd0;
        end else begin
          timer_s = timer_r + CNT_ONE;
        end
      end
      ST_RUN: begin
        if (!lock_sync_r) begin
          loss_s = 1'b1;
        end else if (bus.relock_req) begin
          state_s    = ST_PLL_RST;
          timer_s    = CNT_ZERO;
          pll_rst_s  = 1'b1;
          core_rst_s = 1'b1;
          ready_s    = 1'b0;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (bus.relock_req) begin
          state_s = ST_PLL_RST;
          timer_s = CNT_ZERO;
          fault_s = 1'b0;
          retry_s = 4'd0;
        end else begin
          state_s = ST_FAULT;
        end
      end
      default: begin
        state_s    = ST_PLL_RST;
        timer_s    = CNT_ZERO;
        pll_rst_s  = 1'b1;
        core_rst_s = 1'b1;
        ready_s    = 1'b0;
      end
    endcase
    if (loss_s) begin
      state_s     = ST_PLL_RST;
      timer_s     = CNT_ZERO;
      lock_lost_s = 1'b1;
      core_rst_s  = 1'b1;
      ready_s     = 1'b0;
      pll_rst_s   = 1'b1;
      lost_s      = (lost_r == 8'hFF) ? lost_r : lost_r + 8'd1;
    end else begin
      lock_lost_s = 1'b0;
    end
  end

  // State, timers, lock synchroniser and registered outputs.
  always_ff @(posedge refclk) begin
    if (rst) begin
      state_r     <= ST_PLL_RST;
      timer_r     <= CNT_ZERO;
      filt_r      <= CNT_ZERO;
      meta_r      <= 1'b0;
      lock_sync_r <= 1'b0;
      pll_rst_r   <= 1'b1;
      core_rst_r  <= 1'b1;
      ready_r     <= 1'b0;
      lock_lost_r <= 1'b0;
      fault_r     <= 1'b0;
      retry_r     <= 4'd0;
      lost_r      <= 8'd0;
    end else begin
      state_r     <= state_s;
      timer_r     <= timer_s;
      filt_r      <= filt_s;
      meta_r      <= bus.pll_locked_in;
      lock_sync_r <= meta_r;
      pll_rst_r   <= pll_rst_s;
      core_rst_r  <= core_rst_s;
      ready_r     <= ready_s;
      lock_lost_r <= lock_lost_s;
      fault_r     <= fault_s;
      retry_r     <= retry_s;
      lost_r      <= lost_s;
    end
  end

  assign bus.pll_rst   = pll_rst_r;
  assign bus.core_rst  = core_rst_r;
  assign bus.ready     = ready_r;
  assign bus.lock_lost = lock_lost_r;
  assign bus.fault     = fault_r;
  assign bus.retry_cnt = retry_r;
  assign bus.lost_cnt  = lost_r;
endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenario tasks with timing checks,
// then randomized lock/relock/reset stimulus compared cycle by cycle against a behavioural model.
module tb_pll_reset_sequencer;
  localparam int RST_HOLD    = 4;
  localparam int TIMEOUT     = 32;
  localparam int FILTER      = 8;
  localparam int CORE_DELAY  = 4;
  localparam int MAX_RETRIES = 2;

  localparam int P_HOLD  = 0;
  localparam int P_ACQ   = 1;
  localparam int P_DELAY = 2;
  localparam int P_RUN   = 3;
  localparam int P_FAULT = 4;

  logic refclk = 1'b0;
  logic rst    = 1'b1;

  pll_reset_sequencer_if bus();

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES    (RST_HOLD),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .FILTER_CYCLES      (FILTER),
    .CORE_DELAY_CYCLES  (CORE_DELAY),
    .MAX_RETRIES        (MAX_RETRIES)
  ) dut (
    .refclk(refclk),
    .rst   (rst),
    .bus   (bus)
  );

  always #10 refclk = ~refclk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: one acquisition phase counts consecutive lock samples instead of tracking sub-states.
  int   m_phase, m_el, m_run;
  logic m_h1, m_h2;
  logic e_pll_rst, e_core_rst, e_ready, e_lock_lost, e_fault;
  int   e_retry, e_lost;

  task automatic model_lose();
    e_lock_lost = 1'b1;
    e_core_rst  = 1'b1;
    e_ready     = 1'b0;
    e_pll_rst   = 1'b1;
    if (e_lost < 255) e_lost++;
    m_phase = P_HOLD;
    m_el    = 0;
  endtask

  task automatic model_step();
    logic lk;
    lk   = m_h2;
    m_h2 = m_h1;
    m_h1 = bus.pll_locked_in;
    if (rst) begin
      m_phase = P_HOLD; m_el = 0; m_run = 0; m_h1 = 1'b0; m_h2 = 1'b0;
      e_pll_rst = 1'b1; e_core_rst = 1'b1; e_ready = 1'b0; e_lock_lost = 1'b0;
      e_fault = 1'b0; e_retry = 0; e_lost = 0;
      return;
    end
    e_lock_lost = 1'b0;
    case (m_phase)
      P_HOLD: begin
        m_el++;
        if (m_el == RST_HOLD) begin
          m_phase = P_ACQ; m_el = 0; m_run = 0; e_pll_rst = 1'b0;
        end
      end
      P_ACQ: begin
        m_el++;
        if (m_el == TIMEOUT) begin
          m_el = 0; m_run = 0; e_pll_rst = 1'b1;
          if (e_retry == MAX_RETRIES) begin
            m_phase = P_FAULT; e_fault = 1'b1;
          end else begin
            e_retry++; m_phase = P_HOLD;
          end
        end else begin
          m_run = lk ? m_run + 1 : 0;
          if (m_run == FILTER + 1) begin
            m_phase = P_DELAY; m_el = 0;
          end
        end
      end
      P_DELAY: begin
        if (!lk) model_lose();
        else begin
          m_el++;
          if (m_el == CORE_DELAY) begin
            m_phase = P_RUN; e_core_rst = 1'b0; e_ready = 1'b1; e_retry = 0;
          end
        end
      end
      P_RUN: begin
        if (!lk) model_lose();
        else if (bus.relock_req) begin
          m_phase = P_HOLD; m_el = 0; e_pll_rst = 1'b1; e_core_rst = 1'b1; e_ready = 1'b0;
        end
      end
      P_FAULT: begin
        if (bus.relock_req) begin
          m_phase = P_HOLD; m_el = 0; e_fault = 1'b0; e_retry = 0;
        end
      end
      default: m_phase = P_HOLD;
    endcase
  endtask

  task automatic tick();
    @(posedge refclk);
    model_step();
    @(negedge refclk);
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.pll_locked_in = 1'b0; bus.relock_req = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.pll_rst, bus.core_rst, bus.ready, bus.lock_lost, bus.fault} !== 5'b11000) begin
      errors++;
      $display("FAIL reset_flags got %b want 11000", {bus.pll_rst, bus.core_rst, bus.ready, bus.lock_lost, bus.fault});
    end
    checks++;
    if (bus.retry_cnt !== 4'd0 || bus.lost_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_counters got retry=%0d lost=%0d want 0 0", bus.retry_cnt, bus.lost_cnt);
    end
  endtask

  task automatic test_bring_up();
    int n;
    rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.pll_rst === 1'b1 && n < 50);
    checks++;
    if (n != RST_HOLD) begin
      errors++; $display("FAIL bringup_pll_rst_edges got %0d want %0d", n, RST_HOLD);
    end
    repeat (5) tick();
    bus.pll_locked_in = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.ready !== 1'b1 && n < 100);
    checks++;
    if (n != 2 + FILTER + CORE_DELAY + 1) begin
      errors++; $display("FAIL bringup_ready_latency got %0d want %0d", n, 2 + FILTER + CORE_DELAY + 1);
    end
    checks++;
    if (bus.core_rst !== 1'b0 || bus.retry_cnt !== 4'd0) begin
      errors++; $display("FAIL bringup_run_outputs got core_rst=%b retry=%0d want 0 0", bus.core_rst, bus.retry_cnt);
    end
  endtask

  task automatic test_glitch();
    int n;
    rst = 1'b1; bus.pll_locked_in = 1'b0; tick(); rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.pll_rst === 1'b1 && n < 50);
    bus.pll_locked_in = 1'b1; repeat (5) tick();
    bus.pll_locked_in = 1'b0; tick();
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++; $display("FAIL glitch_early_ready got %b want 0", bus.ready);
    end
    bus.pll_locked_in = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.ready !== 1'b1 && n < 100);
    checks++;
    if (n != 2 + FILTER + CORE_DELAY + 1) begin
      errors++; $display("FAIL glitch_ready_latency got %0d want %0d", n, 2 + FILTER + CORE_DELAY + 1);
    end
    checks++;
    if (bus.retry_cnt !== 4'd0) begin
      errors++; $display("FAIL glitch_no_timeout got retry=%0d want 0", bus.retry_cnt);
    end
  endtask

  task automatic test_never_locks();
    int   n, falls;
    logic prev;
    rst = 1'b1; bus.pll_locked_in = 1'b0; tick(); rst = 1'b0;
    n = 0; falls = 0; prev = 1'b1;
    while (bus.fault !== 1'b1 && n < 400) begin
      tick(); n++;
      if (prev === 1'b1 && bus.pll_rst === 1'b0) begin
        checks++;
        if (n != RST_HOLD + falls * (RST_HOLD + TIMEOUT)) begin
          errors++; $display("FAIL nolock_fall_time got %0d want %0d", n, RST_HOLD + falls * (RST_HOLD + TIMEOUT));
        end
        falls++;
      end
      prev = bus.pll_rst;
    end
    checks++;
    if (n != (MAX_RETRIES + 1) * (RST_HOLD + TIMEOUT) || falls != MAX_RETRIES + 1) begin
      errors++; $display("FAIL nolock_fault_time got cycle=%0d pulses=%0d want %0d %0d",
                         n, falls, (MAX_RETRIES + 1) * (RST_HOLD + TIMEOUT), MAX_RETRIES + 1);
    end
    repeat (5) tick();
    checks++;
    if ({bus.pll_rst, bus.core_rst, bus.ready, bus.fault} !== 4'b1101 || bus.retry_cnt !== 4'd2) begin
      errors++; $display("FAIL nolock_fault_hold got rst/core/ready/fault=%b retry=%0d want 1101 2",
                         {bus.pll_rst, bus.core_rst, bus.ready, bus.fault}, bus.retry_cnt);
    end
    bus.relock_req = 1'b1; tick(); bus.relock_req = 1'b0;
    checks++;
    if (bus.fault !== 1'b0 || bus.retry_cnt !== 4'd0 || bus.pll_rst !== 1'b1) begin
      errors++; $display("FAIL nolock_relock_clear got fault=%b retry=%0d pll_rst=%b want 0 0 1",
                         bus.fault, bus.retry_cnt, bus.pll_rst);
    end
    n = 0;
    do begin tick(); n++; end while (bus.pll_rst === 1'b1 && n < 50);
    checks++;
    if (n != RST_HOLD) begin
      errors++; $display("FAIL nolock_restart_hold got %0d want %0d", n, RST_HOLD);
    end
  endtask

  task automatic test_loss_in_run();
    int n;
    rst = 1'b1; bus.pll_locked_in = 1'b1; tick(); rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.ready !== 1'b1 && n < 200);
    bus.pll_locked_in = 1'b0;
    tick(); tick();
    checks++;
    if (bus.core_rst !== 1'b0 || bus.lock_lost !== 1'b0) begin
      errors++; $display("FAIL loss_early got core_rst=%b lock_lost=%b want 0 0", bus.core_rst, bus.lock_lost);
    end
    tick();
    checks++;
    if ({bus.core_rst, bus.ready, bus.lock_lost, bus.pll_rst} !== 4'b1011 || bus.lost_cnt !== 8'd1) begin
      errors++; $display("FAIL loss_edge got core/ready/lost/pll=%b lost_cnt=%0d want 1011 1",
                         {bus.core_rst, bus.ready, bus.lock_lost, bus.pll_rst}, bus.lost_cnt);
    end
    tick();
    checks++;
    if (bus.lock_lost !== 1'b0) begin
      errors++; $display("FAIL loss_pulse_width got %b want 0", bus.lock_lost);
    end
    bus.pll_locked_in = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.ready !== 1'b1 && n < 200);
    checks++;
    if (bus.ready !== 1'b1 || bus.lost_cnt !== 8'd1 || bus.retry_cnt !== 4'd0) begin
      errors++; $display("FAIL loss_reacquire got ready=%b lost=%0d retry=%0d want 1 1 0",
                         bus.ready, bus.lost_cnt, bus.retry_cnt);
    end
  endtask

  task automatic test_simultaneous();
    int n;
    bus.pll_locked_in = 1'b0; tick(); tick();
    bus.relock_req = 1'b1; tick(); bus.relock_req = 1'b0;
    checks++;
    if (bus.lock_lost !== 1'b1 || bus.lost_cnt !== 8'd2 || bus.core_rst !== 1'b1 || bus.pll_rst !== 1'b1) begin
      errors++; $display("FAIL simul_loss_wins got lock_lost=%b lost=%0d core=%b pll=%b want 1 2 1 1",
                         bus.lock_lost, bus.lost_cnt, bus.core_rst, bus.pll_rst);
    end
    bus.pll_locked_in = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.ready !== 1'b1 && n < 200);
    bus.relock_req = 1'b1; tick(); bus.relock_req = 1'b0;
    checks++;
    if ({bus.lock_lost, bus.pll_rst, bus.core_rst, bus.ready} !== 4'b0110 || bus.lost_cnt !== 8'd2) begin
      errors++; $display("FAIL relock_in_run got lost/pll/core/ready=%b lost=%0d want 0110 2",
                         {bus.lock_lost, bus.pll_rst, bus.core_rst, bus.ready}, bus.lost_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    rst = 1'b1; bus.pll_locked_in = 1'b0; tick(); rst = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.pll_rst === 1'b1 && n < 50);
    bus.pll_locked_in = 1'b1; repeat (6) tick();
    rst = 1'b1; tick();
    checks++;
    if ({bus.pll_rst, bus.core_rst, bus.ready, bus.lock_lost, bus.fault} !== 5'b11000 ||
        bus.retry_cnt !== 4'd0 || bus.lost_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_in_filter got flags=%b retry=%0d lost=%0d want 11000 0 0",
                         {bus.pll_rst, bus.core_rst, bus.ready, bus.lock_lost, bus.fault}, bus.retry_cnt, bus.lost_cnt);
    end
    rst = 1'b0; bus.pll_locked_in = 1'b0;
    n = 0;
    do begin tick(); n++; end while (bus.fault !== 1'b1 && n < 400);
    checks++;
    if (bus.fault !== 1'b1) begin
      errors++; $display("FAIL rst_reach_fault got %b want 1", bus.fault);
    end
    rst = 1'b1; tick();
    checks++;
    if ({bus.pll_rst, bus.core_rst, bus.ready, bus.lock_lost, bus.fault} !== 5'b11000 ||
        bus.retry_cnt !== 4'd0 || bus.lost_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_in_fault got flags=%b retry=%0d lost=%0d want 11000 0 0",
                         {bus.pll_rst, bus.core_rst, bus.ready, bus.lock_lost, bus.fault}, bus.retry_cnt, bus.lost_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int          seg;
    logic [16:0] got, want;
    rst = 1'b1; bus.pll_locked_in = 1'b0; bus.relock_req = 1'b0; tick(); rst = 1'b0;
    seg = 0;
    for (int i = 0; i < 4000; i++) begin
      if (seg <= 0) begin
        bus.pll_locked_in = ~bus.pll_locked_in;
        if (bus.pll_locked_in) seg = int'($urandom_range(1, 60));
        else if ($urandom_range(0, 7) == 0) seg = int'($urandom_range(40, 120));
        else seg = int'($urandom_range(1, 12));
      end
      seg--;
      bus.relock_req = ($urandom_range(0, 47) == 0);
      rst = ($urandom_range(0, 999) == 0);
      tick();
      got  = {bus.pll_rst, bus.core_rst, bus.ready, bus.lock_lost, bus.fault, bus.retry_cnt, bus.lost_cnt};
      want = {e_pll_rst, e_core_rst, e_ready, e_lock_lost, e_fault, 4'(e_retry), 8'(e_lost)};
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL random_outputs cycle %0d got %h want %h", i, got, want);
      end
    end
    rst = 1'b0; bus.relock_req = 1'b0;
  endtask

  initial begin
    bus.pll_locked_in = 1'b0;
    bus.relock_req    = 1'b0;
    test_reset();
    test_bring_up();
    test_glitch();
    test_never_locks();
    test_loss_in_run();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
